// File: rtl/vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// vga_write_arbiter
//
// Shares the single VGA pixel-write port between the drawing engines
// (0 = tower placer, 1 = car animator, 2 = background/erase restorer).
// A requester gets the port for a bounded burst of MAX_BURST pixels and is
// then moved to the back of a round-robin queue. Every ownership change goes
// through one idle bubble cycle. All outputs are registered. A pixel whose
// address is outside the map is dropped and flagged.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   req        : per-requester request level, held while it has pixels
//   wr         : per-requester pixel strobe, only honoured while granted
//   colour_in  : packed colours, requester i at [9i+8:9i]
//   coord_in   : packed linear addresses, requester i at [15i+14:15i]
//   gnt        : registered one-hot grant
//   vga_colour : registered pixel colour to the VGA adapter
//   vga_coord  : registered pixel address to the VGA adapter
//   vga_wren   : registered write enable, one pulse per written pixel
//   busy       : high while a requester owns the port
//   oob_err    : sticky flag, an out-of-range pixel was dropped
// ---------------------------------------------------------------------------
module vga_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 64,
  parameter int NPIX      = 19200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wr,
  input  logic [9*NREQ-1:0]    colour_in,
  input  logic [15*NREQ-1:0]   coord_in,
  output logic [NREQ-1:0]      gnt,
  output logic [8:0]           vga_colour,
  output logic [14:0]          vga_coord,
  output logic                 vga_wren,
  output logic                 busy,
  output logic                 oob_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // burst_cnt value seen while the final pixel of a burst is being accepted
  localparam logic [7:0]  LAST_CNT = 8'(MAX_BURST - 1);
  localparam logic [15:0] NPIX_W   = 16'(NPIX);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] next_owner;
  logic [IDXW-1:0] cidx;
  logic            any_req;
  logic [7:0]      burst_cnt;
  logic            own_req;
  logic            own_wr;
  logic [8:0]      own_colour;
  logic [14:0]     own_coord;
  logic            in_range;

  // Round-robin pick: scan ptr+1, ptr+2, ... (mod NREQ). The scan runs from
  // the farthest candidate to the nearest, so the nearest requesting one is
  // the last assignment and therefore wins.
  always_comb begin
    next_owner = '0;
    cidx       = '0;
    any_req    = |req;
    for (int i = NREQ; i >= 1; i--) begin
      cidx = IDXW'((int'(ptr) + i) % NREQ);
      if (req[cidx]) begin
        next_owner = cidx;
      end
    end
  end

  // Select the current owner's request, strobe and pixel data.
  always_comb begin
    own_req    = 1'b0;
    own_wr     = 1'b0;
    own_colour = '0;
    own_coord  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDXW'(i)) begin
        own_req    = req[i];
        own_wr     = wr[i];
        own_colour = colour_in[9*i +: 9];
        own_coord  = coord_in[15*i +: 15];
      end
    end
  end

  assign in_range = ({1'b0, own_coord} < NPIX_W);

  // Arbitration FSM with registered outputs. Releasing always lands in IDLE
  // with gnt cleared, which is what produces the single bubble cycle and
  // keeps gnt from ever switching directly between two requesters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      vga_wren   <= 1'b0;
      vga_colour <= '0;
      vga_coord  <= '0;
      busy       <= 1'b0;
      oob_err    <= 1'b0;
      ptr        <= IDXW'(NREQ - 1);
      owner      <= '0;
      burst_cnt  <= '0;
    end else begin
      vga_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= next_owner;
            gnt       <= NREQ'(1) << next_owner;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= OWN;
          end
        end
        OWN: begin
          if (!own_req) begin
            // Owner is done; a strobe in this same cycle is ignored.
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= owner;
            state <= IDLE;
          end else if (own_wr) begin
            if (in_range) begin
              vga_wren   <= 1'b1;
              vga_colour <= own_colour;
              vga_coord  <= own_coord;
            end else begin
              oob_err <= 1'b1;
            end
            // Dropped pixels still use up the burst allowance.
            if (burst_cnt != 8'hFF) begin
              burst_cnt <= burst_cnt + 8'd1;
            end
            if (burst_cnt >= LAST_CNT) begin
              gnt   <= '0;
              busy  <= 1'b0;
              ptr   <= owner;
              state <= IDLE;
            end
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_write_arbiter
//
// Self-checking bench for vga_write_arbiter. A behavioural reference model
// tracks who owns the port, how many pixels it has written this grant and
// the round-robin pointer, and predicts every output each cycle. Scenario
// tasks drive directed and random traffic and compare on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_write_arbiter;

  localparam int NREQ      = 3;
  localparam int MAX_BURST = 64;
  localparam int NPIX      = 19200;

  logic                 clk       = 1'b0;
  logic                 reset     = 1'b1;
  logic [NREQ-1:0]      req       = '0;
  logic [NREQ-1:0]      wr        = '0;
  logic [9*NREQ-1:0]    colour_in = '0;
  logic [15*NREQ-1:0]   coord_in  = '0;
  logic [NREQ-1:0]      gnt;
  logic [8:0]           vga_colour;
  logic [14:0]          vga_coord;
  logic                 vga_wren;
  logic                 busy;
  logic                 oob_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_write_arbiter #(
    .NREQ(NREQ), .MAX_BURST(MAX_BURST), .NPIX(NPIX)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr),
    .colour_in(colour_in), .coord_in(coord_in), .gnt(gnt),
    .vga_colour(vga_colour), .vga_coord(vga_coord), .vga_wren(vga_wren),
    .busy(busy), .oob_err(oob_err)
  );

  // Reference model: who owns the port, pixels used this grant, and who
  // was served last. Outputs change on the rising edge like the hardware.
  logic            m_own    = 1'b0;
  int              m_owner  = 0;
  int              m_ptr    = NREQ - 1;
  int              m_cnt    = 0;
  logic            m_found  = 1'b0;
  logic [NREQ-1:0] m_gnt    = '0;
  logic            m_wren   = 1'b0;
  logic            m_oob    = 1'b0;
  logic [8:0]      m_colour = '0;
  logic [14:0]     m_coord  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own = 1'b0; m_owner = 0; m_ptr = NREQ - 1; m_cnt = 0;
      m_gnt = '0; m_wren = 1'b0; m_oob = 1'b0; m_colour = '0; m_coord = '0;
    end else if (!m_own) begin
      m_wren = 1'b0;
      if (req != '0) begin
        m_found = 1'b0;
        for (int s = 1; s <= NREQ; s++) begin
          if (!m_found && req[(m_ptr + s) % NREQ]) begin
            m_found = 1'b1;
            m_owner = (m_ptr + s) % NREQ;
          end
        end
        m_own = 1'b1;
        m_cnt = 0;
        m_gnt = '0;
        m_gnt[m_owner] = 1'b1;
      end
    end else begin
      m_wren = 1'b0;
      if (!req[m_owner]) begin
        m_own = 1'b0; m_gnt = '0; m_ptr = m_owner;
      end else if (wr[m_owner]) begin
        m_cnt = m_cnt + 1;
        if (int'(coord_in[m_owner*15 +: 15]) < NPIX) begin
          m_wren   = 1'b1;
          m_colour = colour_in[m_owner*9 +: 9];
          m_coord  = coord_in[m_owner*15 +: 15];
        end else begin
          m_oob = 1'b1;
        end
        if (m_cnt == MAX_BURST) begin
          m_own = 1'b0; m_gnt = '0; m_ptr = m_owner;
        end
      end
    end
  end

  logic [29:0] dut_obs;
  logic [29:0] mdl_obs;
  assign dut_obs = {gnt, vga_wren, busy, oob_err, vga_colour, vga_coord};
  assign mdl_obs = {m_gnt, m_wren, m_own, m_oob, m_colour, m_coord};

  task automatic set_pix(input int i, input logic [8:0] c, input logic [14:0] a);
    colour_in[i*9 +: 9]   = c;
    coord_in[i*15 +: 15]  = a;
  endtask

  function automatic logic [14:0] rand_coord();
    return 15'($urandom_range(NPIX - 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; wr = '0; colour_in = '0; coord_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req = '1; wr = '1;
    for (int i = 0; i < NREQ; i++) set_pix(i, 9'($urandom), rand_coord());
    repeat (3) @(negedge clk);
    n_checks++;
    if (gnt !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_gnt got=%b want=000", gnt);
    end
    n_checks++;
    if (vga_wren !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_wren got=%b want=0", vga_wren);
    end
    n_checks++;
    if ({busy, oob_err} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_flags busy/oob got=%b want=00", {busy, oob_err});
    end
    n_checks++;
    if ({vga_colour, vga_coord} !== 24'h0) begin
      n_fail++; $display("[TB] FAIL reset_data got=%h want=0", {vga_colour, vga_coord});
    end
    n_checks++;
    if (dut_obs !== mdl_obs) begin
      n_fail++; $display("[TB] FAIL reset_model got=%h want=%h", dut_obs, mdl_obs);
    end
  endtask

  // Continues from test_reset with all three requesting and streaming.
  task automatic test_round_robin();
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] seen[$];
    logic [NREQ-1:0] want[4];
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
    prev = '0;
    reset = 1'b0;
    for (int cyc = 0; cyc < 205; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL rr_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      if (cyc == 0) begin
        n_checks++;
        if (gnt !== 3'b001) begin
          n_fail++; $display("[TB] FAIL rr_first_grant got=%b want=001", gnt);
        end
      end
      if (gnt != '0 && gnt != prev) begin
        seen.push_back(gnt);
        n_checks++;
        if (prev !== '0) begin
          n_fail++; $display("[TB] FAIL rr_bubble prev=%b now=%b want prev=000", prev, gnt);
        end
      end
      prev = gnt;
      for (int i = 0; i < NREQ; i++) set_pix(i, 9'($urandom), rand_coord());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (seen.size() <= i) begin
        n_fail++; $display("[TB] FAIL rr_order[%0d] got=none want=%b", i, want[i]);
      end else if (seen[i] !== want[i]) begin
        n_fail++; $display("[TB] FAIL rr_order[%0d] got=%b want=%b", i, seen[i], want[i]);
      end
    end
  endtask

  task automatic test_tower_alone();
    int n = 0;
    int wcnt = 0;
    int drop_at = -1;
    logic prev_g = 1'b0;
    do_reset();
    req[0] = 1'b1; wr[0] = 1'b1; set_pix(0, 9'h1FF, 15'd0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL tower_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      if (vga_wren) begin
        n_checks++;
        if (vga_coord !== 15'(wcnt) || vga_colour !== 9'h1FF) begin
          n_fail++; $display("[TB] FAIL tower_pixel got=%h/%0d want=1ff/%0d", vga_colour, vga_coord, wcnt);
        end
        wcnt++;
      end
      if (drop_at >= 0 && cyc == drop_at + 1) begin
        n_checks++;
        if ({gnt, busy} !== 4'b0000) begin
          n_fail++; $display("[TB] FAIL tower_release gnt/busy got=%b want=0000", {gnt, busy});
        end
      end
      if (prev_g) n++;
      if (n < 10) begin
        set_pix(0, 9'h1FF, 15'(n));
      end else if (req[0]) begin
        req[0] = 1'b0; drop_at = cyc;
      end
      prev_g = gnt[0] & req[0] & wr[0];
    end
    n_checks++;
    if (wcnt != 10) begin
      n_fail++; $display("[TB] FAIL tower_count got=%0d want=10", wcnt);
    end
  endtask

  task automatic test_max_burst();
    logic [NREQ-1:0] prev = '0;
    int wcnt = 0;
    int bursts = 0;
    int bubble_cyc = -10;
    do_reset();
    req[1] = 1'b1; wr[1] = 1'b1; set_pix(1, 9'($urandom), rand_coord());
    for (int cyc = 0; cyc < 135; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL burst_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      if (vga_wren) wcnt++;
      if (gnt == '0 && prev != '0) begin
        n_checks++;
        if (wcnt != MAX_BURST) begin
          n_fail++; $display("[TB] FAIL burst_len got=%0d want=%0d", wcnt, MAX_BURST);
        end
        wcnt = 0; bursts++; bubble_cyc = cyc;
      end
      if (cyc == bubble_cyc + 1) begin
        n_checks++;
        if (gnt !== 3'b010) begin
          n_fail++; $display("[TB] FAIL burst_regrant got=%b want=010", gnt);
        end
      end
      prev = gnt;
      set_pix(1, 9'($urandom), rand_coord());
    end
    n_checks++;
    if (bursts != 2) begin
      n_fail++; $display("[TB] FAIL burst_number got=%0d want=2", bursts);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] prev = '0;
    logic [NREQ-1:0] seen[$];
    logic [NREQ-1:0] want[3];
    int t_n = 0;
    logic prev_t = 1'b0;
    int bubble_cyc = -10;
    want[0] = 3'b010; want[1] = 3'b001; want[2] = 3'b010;
    do_reset();
    req[1] = 1'b1; wr[1] = 1'b1; set_pix(1, 9'($urandom), rand_coord());
    for (int cyc = 0; cyc < 90; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL fair_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      if (gnt == '0 && prev == 3'b010 && bubble_cyc < 0) bubble_cyc = cyc;
      if (cyc == bubble_cyc + 1) begin
        n_checks++;
        if (gnt !== 3'b001) begin
          n_fail++; $display("[TB] FAIL fair_tower_next got=%b want=001", gnt);
        end
      end
      if (gnt != '0 && gnt != prev) seen.push_back(gnt);
      prev = gnt;
      if (cyc == 20) begin
        req[0] = 1'b1; wr[0] = 1'b1;
      end
      if (prev_t) t_n++;
      if (t_n >= 5) req[0] = 1'b0;
      prev_t = gnt[0] & req[0] & wr[0];
      set_pix(0, 9'($urandom), rand_coord());
      set_pix(1, 9'($urandom), rand_coord());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (seen.size() <= i) begin
        n_fail++; $display("[TB] FAIL fair_order[%0d] got=none want=%b", i, want[i]);
      end else if (seen[i] !== want[i]) begin
        n_fail++; $display("[TB] FAIL fair_order[%0d] got=%b want=%b", i, seen[i], want[i]);
      end
    end
  endtask

  task automatic test_oob();
    logic [NREQ-1:0] prev = '0;
    logic prev_g = 1'b0;
    int n = 0;
    int wcnt = 0;
    logic [14:0] a;
    do_reset();
    req[0] = 1'b1; wr[0] = 1'b1; set_pix(0, 9'h0AA, 15'd100);
    for (int cyc = 0; cyc < 75; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL oob_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      if (vga_wren) wcnt++;
      if (prev_g) begin
        if (n == 1) begin
          n_checks++;
          if ({oob_err, vga_wren, vga_coord} !== {1'b1, 1'b0, 15'd100}) begin
            n_fail++; $display("[TB] FAIL oob_drop oob/wren/coord got=%b/%b/%0d want=1/0/100", oob_err, vga_wren, vga_coord);
          end
        end
        if (n == 3) begin
          n_checks++;
          if ({vga_wren, vga_coord} !== {1'b1, 15'd103}) begin
            n_fail++; $display("[TB] FAIL oob_recover wren/coord got=%b/%0d want=1/103", vga_wren, vga_coord);
          end
        end
        n++;
      end
      if (gnt == '0 && prev != '0) begin
        n_checks++;
        if (wcnt != MAX_BURST - 2) begin
          n_fail++; $display("[TB] FAIL oob_burst_count got=%0d want=%0d", wcnt, MAX_BURST - 2);
        end
      end
      prev = gnt;
      a = (n == 1) ? 15'd19200 : (n == 2) ? 15'd32767 : 15'(100 + n);
      set_pix(0, 9'h0AA, a);
      prev_g = gnt[0] & req[0] & wr[0];
    end
    n_checks++;
    if (oob_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL oob_sticky got=%b want=1", oob_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic hit = 1'b0;
    do_reset();
    req[1] = 1'b1; wr[1] = 1'b1; set_pix(1, 9'($urandom), rand_coord());
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL rstmid_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      if (vga_wren && cyc >= 10) hit = 1'b1;
      set_pix(1, 9'($urandom), rand_coord());
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("[TB] FAIL rstmid_no_write got=0 want=1");
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt, vga_wren, busy} !== 5'b00000) begin
      n_fail++; $display("[TB] FAIL rstmid_async gnt/wren/busy got=%b want=00000", {gnt, vga_wren, busy});
    end
    req = '1; wr = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001) begin
      n_fail++; $display("[TB] FAIL rstmid_restart got=%b want=001", gnt);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] prev = '0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (dut_obs !== mdl_obs) begin
        n_fail++; $display("[TB] FAIL rand_model t=%0t got=%h want=%h", $time, dut_obs, mdl_obs);
      end
      n_checks++;
      if (!$onehot0(gnt) || (prev != '0 && gnt != '0 && gnt != prev)) begin
        n_fail++; $display("[TB] FAIL rand_gnt_shape prev=%b got=%b want one-hot via 000", prev, gnt);
      end
      prev = gnt;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(19) == 0) req[i] = ~req[i];
        wr[i] = ($urandom_range(3) != 0);
        set_pix(i, 9'($urandom),
                ($urandom_range(15) == 0) ? 15'(NPIX + $urandom_range(32767 - NPIX))
                                          : rand_coord());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_tower_alone();
    test_max_burst();
    test_fairness();
    test_oob();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
Shares the single VGA pixel-write port between the game's drawing engines: tower placer, car animator and background/erase restorer. Round-robin arbitration with bounded bursts, so the cars stage cannot starve tower drawing and vice versa. Replaces the combinational tower/car colour mux. Registered single-port output feeds the VGA adapter, and out-of-range pixels are filtered.

Parameters:
NREQ, 3, number of requesters (index 0 = tower, 1 = car, 2 = background)
MAX_BURST, 64, max pixels written per grant before forced release (1..255)
NPIX, 19200, valid linear pixel addresses 0..NPIX-1 (160x120 map)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request, level; held while requester has pixels
wr  in  NREQ  per-requester pixel strobe; counted only when granted
colour_in  in  9*NREQ  packed colours, requester i at [9i+8:9i]
coord_in  in  15*NREQ  packed linear addresses, requester i at [15i+14:15i]
gnt  out  NREQ  one-hot grant, registered
vga_colour  out  9  registered pixel colour
vga_coord  out  15  registered pixel address
vga_wren  out  1  registered write enable, one-cycle pulse per accepted pixel
busy  out  1  high in OWN state
oob_err  out  1  sticky: an out-of-range coord was dropped; cleared only by reset

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, vga_wren=0, vga_colour=0, vga_coord=0, busy=0, oob_err=0, ptr=NREQ-1, burst_cnt=0.
- IDLE: gnt=0. If any req is high, select the first requester with req high, scanning ptr+1, ptr+2, ... (mod NREQ). Set gnt one-hot to it next cycle, burst_cnt=0, go to OWN. No req: stay in IDLE.
- OWN (owner k): accepted pixel = gnt[k] & req[k] & wr[k]. On each accepted pixel:
  - if coord_in[k] < NPIX: next cycle vga_wren=1, vga_colour/vga_coord = that pixel's data (latency 1 cycle from wr to vga_wren);
  - else: vga_wren=0, oob_err set, pixel dropped but still counted in burst_cnt.
  - burst_cnt increments on every accepted pixel.
- vga_wren=0 on any cycle without an accepted pixel. vga_colour/vga_coord hold their last value.
- Release from OWN. The next cycle is IDLE with gnt=0, giving exactly one bubble cycle; ptr=k. Release condition:
  - req[k] low (that cycle's wr[k] ignored), or
  - accepted pixel with burst_cnt reaching MAX_BURST (the MAX_BURST-th pixel is written).
- Round-robin: after release, k has lowest priority. If only k still requests, it is re-granted after the bubble.
- wr on non-granted requesters is ignored; requesters stall until gnt[i].
- Simultaneous req on all in IDLE with ptr=NREQ-1: grant index 0 first, then 1, then 2.
- Reset mid-burst: pending pixel lost, vga_wren forced 0 immediately (async).
- burst_cnt is 8 bits and saturates safely; MAX_BURST=1 gives one pixel per grant.
- gnt is never multi-hot and never changes except via IDLE.

Test Plan:
- Reset with req=3'b111 held → gnt=000, vga_wren=0. Release reset → gnt=001 after 1 cycle, then 010, then 100 across bursts, each separated by one gnt=000 cycle.
- Tower alone: req[0]=1, wr[0]=1 for 10 cycles, coord 0..9, colour 9'h1FF → vga_wren high 10 cycles, lagging by 1, vga_coord 0..9. req[0] drop → IDLE next cycle.
- MAX_BURST=64: car requests continuously with wr=1, tower idle → 64 writes, 1 bubble cycle, car re-granted, next 64 writes.
- Fairness: car streaming, tower raises req mid-burst → tower granted immediately after car's 64th pixel + bubble. Car not re-granted before tower releases.
- coord_in=19200 (and 32767) on an accepted pixel → no vga_wren, oob_err=1 sticky, burst_cnt still incremented. Next valid pixel is written normally.
- Assert reset while vga_wren=1 mid-burst → vga_wren, gnt, busy drop the same cycle. After release, arbitration restarts with requester 0.
